// File: rtl/fpu8_op_scheduler_if.sv
// Requester, exception-checker, arithmetic-unit and response signals of the FPU8 op scheduler.
interface fpu8_op_scheduler_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [1:0] req0_op;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [1:0] req1_op;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic [1:0] exc_op;
  logic [7:0] exc_a;
  logic [7:0] exc_b;
  logic       exc_flag;
  logic       fu_start;
  logic [1:0] fu_op;
  logic [7:0] fu_a;
  logic [7:0] fu_b;
  logic       fu_done;
  logic [7:0] fu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_exc;
  logic       rsp_timeout;

  // Scheduler side
  modport master (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output exc_op, exc_a, exc_b,
    input  exc_flag,
    output fu_start, fu_op, fu_a, fu_b,
    input  fu_done, fu_result,
    output rsp_valid, rsp_id, rsp_result, rsp_exc, rsp_timeout,
    input  rsp_ready
  );

  // Requester / checker / unit / consumer side
  modport slave (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  exc_op, exc_a, exc_b,
    output exc_flag,
    input  fu_start, fu_op, fu_a, fu_b,
    output fu_done, fu_result,
    input  rsp_valid, rsp_id, rsp_result, rsp_exc, rsp_timeout,
    output rsp_ready
  );
endinterface

// File: rtl/fpu8_op_scheduler.sv
// Round-robin scheduler sharing one 8-bit FPU unit between two requesters, with exception screening.
// Define FPU8_SCHED_STATS_EN to add the ops_cnt / exc_cnt saturating statistics outputs.
module fpu8_op_scheduler #(
  parameter int unsigned EXEC_TIMEOUT = 15,
  parameter logic [7:0]  EXC_RESULT   = 8'hFF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fpu8_op_scheduler_if.master  bus
`ifdef FPU8_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]     ops_cnt,
  output logic [CNT_W-1:0]     exc_cnt
`endif
);

  localparam int unsigned TMR_W = $clog2(EXEC_TIMEOUT + 1);

  if (EXEC_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("fpu8_op_scheduler: EXEC_TIMEOUT and CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, CHECK, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       op_q;
  logic [7:0]       a_q, b_q;
  logic             id_q;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             fu_start_q, fu_start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_result_q, rsp_result_d;
  logic             rsp_exc_q, rsp_exc_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             grant, accept, handshake;

  // Next-state, arbitration and response capture
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    timer_d        = timer_q;
    fu_start_d     = 1'b0;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_exc_d      = rsp_exc_q;
    rsp_timeout_d  = rsp_timeout_q;
    grant          = 1'b0;
    accept         = 1'b0;
    handshake      = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        grant  = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
        accept = bus.req0_valid || bus.req1_valid;
        bus.req0_ready = accept && !grant;
        bus.req1_ready = accept && grant;
        if (accept) state_d = CHECK;
      end
      CHECK: begin
        if (bus.exc_flag) begin
          rsp_valid_d   = 1'b1;
          rsp_result_d  = EXC_RESULT;
          rsp_exc_d     = 1'b1;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else begin
          timer_d    = '0;
          fu_start_d = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        timer_d = timer_q + TMR_W'(1);
        // A done arriving on the timeout cycle still wins
        if (bus.fu_done) begin
          rsp_valid_d   = 1'b1;
          rsp_result_d  = bus.fu_result;
          rsp_exc_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (timer_q == TMR_W'(EXEC_TIMEOUT - 1)) begin
          rsp_valid_d   = 1'b1;
          rsp_result_d  = EXC_RESULT;
          rsp_exc_d     = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          handshake     = 1'b1;
          rsp_valid_d   = 1'b0;
          rsp_exc_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          last_grant_d  = id_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operation latch, timer and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q  <= 1'b1;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= 1'b0;
      timer_q       <= '0;
      fu_start_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_exc_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= grant ? bus.req1_op : bus.req0_op;
        a_q  <= grant ? bus.req1_a  : bus.req0_a;
        b_q  <= grant ? bus.req1_b  : bus.req0_b;
        id_q <= grant;
      end
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      fu_start_q    <= fu_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_exc_q     <= rsp_exc_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

`ifdef FPU8_SCHED_STATS_EN
  // Saturating handshake statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_cnt <= '0;
      exc_cnt <= '0;
    end else if (handshake) begin
      if (ops_cnt != {CNT_W{1'b1}}) ops_cnt <= ops_cnt + CNT_W'(1);
      if ((rsp_exc_q || rsp_timeout_q) && exc_cnt != {CNT_W{1'b1}}) exc_cnt <= exc_cnt + CNT_W'(1);
    end
  end
`endif

  assign bus.exc_op      = op_q;
  assign bus.exc_a       = a_q;
  assign bus.exc_b       = b_q;
  assign bus.fu_start    = fu_start_q;
  assign bus.fu_op       = op_q;
  assign bus.fu_a        = a_q;
  assign bus.fu_b        = b_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_exc     = rsp_exc_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_fpu8_op_scheduler.sv
// Directed self-checking bench for fpu8_op_scheduler with a behavioural checker and arithmetic unit.
module tb_fpu8_op_scheduler;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  fpu8_op_scheduler_if bus ();

`ifdef FPU8_SCHED_STATS_EN
  logic [15:0] ops_cnt, exc_cnt;
  fpu8_op_scheduler dut (.clk(clk), .rst(rst), .bus(bus), .ops_cnt(ops_cnt), .exc_cnt(exc_cnt));
`else
  fpu8_op_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exception checker: exponent all-ones (inf/NaN) on either operand, or divide by zero
  assign bus.exc_flag = (bus.exc_a[6:3] == 4'hF) || (bus.exc_b[6:3] == 4'hF) ||
                        (bus.exc_op == OP_DIV && bus.exc_b[6:0] == 7'h00);

  // Arithmetic unit: done fu_delay cycles after the start cycle; negative delay = never
  int         fu_delay = 0;
  logic [7:0] fu_res = 8'h00;
  int         fu_cnt = 0;
  bit         fu_busy = 0;
  always @(negedge clk) begin
    bus.fu_done = 1'b0;
    if (rst) fu_busy = 0;
    else if (bus.fu_start) begin fu_busy = 1; fu_cnt = fu_delay; end
    else if (fu_busy) fu_cnt = fu_cnt - 1;
    if (fu_busy && fu_cnt == 0 && fu_delay >= 0) begin
      bus.fu_done = 1'b1;
      bus.fu_result = fu_res;
      fu_busy = 0;
    end
  end

  // Monitor sampled just before each rising edge
  int fu_starts = 0;
  int start_cyc = 0;
  int grant_log[$];
  int grant_cyc[$];
  int run0 = 0, run1 = 0, max_run0 = 0, max_run1 = 0;
  always @(negedge clk) begin
    #2;
    if (bus.fu_start) begin fu_starts++; start_cyc = cyc; end
    if (bus.req0_valid && bus.req0_ready) begin grant_log.push_back(0); grant_cyc.push_back(cyc); end
    if (bus.req1_valid && bus.req1_ready) begin grant_log.push_back(1); grant_cyc.push_back(cyc); end
    run0 = bus.req0_ready ? run0 + 1 : 0;
    run1 = bus.req1_ready ? run1 + 1 : 0;
    if (run0 > max_run0) max_run0 = run0;
    if (run1 > max_run1) max_run1 = run1;
  end

  task automatic send(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int t_acc, output bit ok);
    ok = 0;
    t_acc = 0;
    if (id == 0) begin bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1; end
    else         begin bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1; end
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) begin ok = 1; t_acc = cyc; end
      @(negedge clk);
    end
    if (id == 0) bus.req0_valid = 1'b0;
    else         bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, output int t_rsp, output bit ok);
    ok = 0;
    t_rsp = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (bus.rsp_valid) begin ok = 1; t_rsp = cyc; end
      else @(negedge clk);
    end
  endtask

  task automatic rsp_handshake();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.fu_start !== 1'b0 || bus.rsp_result !== 8'h00 || bus.exc_a !== 8'h00 ||
        bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
      $display("FAIL reset_outputs: rsp_valid=%b fu_start=%b rsp_result=%h exc_a=%h ready=%b%b, all required 0",
               bus.rsp_valid, bus.fu_start, bus.rsp_result, bus.exc_a, bus.req0_ready, bus.req1_ready);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_op();
    int t, r, s0; bit ok;
    fu_delay = 3; fu_res = 8'h3C; s0 = fu_starts;
    send(0, OP_ADD, 8'h38, 8'h30, t, ok);
    checks++; if (!ok) $display("FAIL clean_accept: req0 not accepted within bound"); else passed++;
    wait_rsp(30, r, ok);
    checks++; if (!ok) $display("FAIL clean_rsp: no rsp_valid within bound"); else passed++;
    checks++; if (r - t !== 6) $display("FAIL clean_latency: got %0d required 6", r - t); else passed++;
    checks++; if (fu_starts - s0 !== 1) $display("FAIL clean_start_pulses: got %0d required 1", fu_starts - s0); else passed++;
    checks++; if (start_cyc - t !== 2) $display("FAIL clean_start_cycle: got T+%0d required T+2", start_cyc - t); else passed++;
    checks++;
    if (bus.rsp_id !== 1'b0 || bus.rsp_result !== 8'h3C || bus.rsp_exc !== 1'b0 || bus.rsp_timeout !== 1'b0 || bus.fu_a !== 8'h38)
      $display("FAIL clean_rsp_fields: id=%b result=%h exc=%b timeout=%b fu_a=%h, required 0 3c 0 0 38",
               bus.rsp_id, bus.rsp_result, bus.rsp_exc, bus.rsp_timeout, bus.fu_a);
    else passed++;
    rsp_handshake();
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL clean_drop: rsp_valid=%b required 0", bus.rsp_valid); else passed++;
  endtask

  task automatic test_exception();
    int t, r, s0; bit ok;
    s0 = fu_starts;
    send(1, OP_ADD, 8'h78, 8'h00, t, ok);
    checks++; if (!ok) $display("FAIL exc_accept: req1 not accepted within bound"); else passed++;
    wait_rsp(20, r, ok);
    checks++; if (!ok || r - t !== 2) $display("FAIL exc_latency: got %0d required 2 (seen=%0d)", r - t, ok); else passed++;
    checks++; if (fu_starts !== s0) $display("FAIL exc_no_start: fu_start pulses %0d required 0", fu_starts - s0); else passed++;
    checks++;
    if (bus.rsp_id !== 1'b1 || bus.rsp_result !== 8'hFF || bus.rsp_exc !== 1'b1 || bus.rsp_timeout !== 1'b0 || bus.exc_a !== 8'h78)
      $display("FAIL exc_rsp_fields: id=%b result=%h exc=%b timeout=%b exc_a=%h, required 1 ff 1 0 78",
               bus.rsp_id, bus.rsp_result, bus.rsp_exc, bus.rsp_timeout, bus.exc_a);
    else passed++;
    rsp_handshake();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_exc !== 1'b0)
      $display("FAIL exc_drop: rsp_valid=%b rsp_exc=%b required 0 0", bus.rsp_valid, bus.rsp_exc); else passed++;
  endtask

  task automatic test_back_to_back();
    int base; bit done;
    fu_delay = 0; fu_res = 8'h11; done = 0;
    base = grant_log.size();
    max_run0 = 0; max_run1 = 0;
    bus.rsp_ready = 1'b1;
    bus.req0_op = OP_ADD; bus.req0_a = 8'h38; bus.req0_b = 8'h30; bus.req0_valid = 1'b1;
    bus.req1_op = OP_MUL; bus.req1_a = 8'h40; bus.req1_b = 8'h38; bus.req1_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (grant_log.size() >= base + 4) done = 1;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (6) @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++; if (!done) $display("FAIL b2b_grants: got %0d grants required 4", grant_log.size() - base); else passed++;
    if (done) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_log[base + i] !== (i % 2)) $display("FAIL b2b_order[%0d]: got %0d required %0d", i, grant_log[base + i], i % 2);
        else passed++;
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (grant_cyc[base + i] - grant_cyc[base + i - 1] !== 4)
          $display("FAIL b2b_interval[%0d]: got %0d required 4", i, grant_cyc[base + i] - grant_cyc[base + i - 1]);
        else passed++;
      end
    end
    checks++; if (max_run0 !== 1 || max_run1 !== 1)
      $display("FAIL b2b_ready_pulse: widths %0d %0d required 1 1", max_run0, max_run1); else passed++;
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL b2b_idle: rsp_valid=%b required 0", bus.rsp_valid); else passed++;
  endtask

  task automatic test_timeout();
    int t, r; bit ok;
    fu_delay = -1;
    send(0, OP_MUL, 8'h40, 8'h40, t, ok);
    wait_rsp(40, r, ok);
    checks++; if (!ok || r - t !== 17) $display("FAIL to_latency: got %0d required 17 (seen=%0d)", r - t, ok); else passed++;
    checks++;
    if (bus.rsp_result !== 8'hFF || bus.rsp_timeout !== 1'b1 || bus.rsp_exc !== 1'b0)
      $display("FAIL to_fields: result=%h timeout=%b exc=%b required ff 1 0", bus.rsp_result, bus.rsp_timeout, bus.rsp_exc);
    else passed++;
    rsp_handshake();
    checks++; if (bus.rsp_timeout !== 1'b0) $display("FAIL to_drop: rsp_timeout=%b required 0", bus.rsp_timeout); else passed++;
    fu_delay = 14; fu_res = 8'h5A;
    send(1, OP_DIV, 8'h40, 8'h38, t, ok);
    wait_rsp(40, r, ok);
    checks++; if (!ok || r - t !== 17) $display("FAIL done_at_to_latency: got %0d required 17 (seen=%0d)", r - t, ok); else passed++;
    checks++;
    if (bus.rsp_result !== 8'h5A || bus.rsp_timeout !== 1'b0 || bus.rsp_id !== 1'b1)
      $display("FAIL done_at_to_fields: result=%h timeout=%b id=%b required 5a 0 1", bus.rsp_result, bus.rsp_timeout, bus.rsp_id);
    else passed++;
    rsp_handshake();
  endtask

  task automatic test_backpressure();
    int t, r; bit ok;
    fu_delay = 0; fu_res = 8'h22;
    send(1, OP_SUB, 8'h30, 8'h38, t, ok);
    wait_rsp(20, r, ok);
    checks++; if (!ok || r - t !== 3) $display("FAIL bp_latency: got %0d required 3 (seen=%0d)", r - t, ok); else passed++;
    bus.req0_op = OP_ADD; bus.req0_a = 8'h30; bus.req0_b = 8'h30; bus.req0_valid = 1'b1;
    bus.req1_op = OP_ADD; bus.req1_a = 8'h30; bus.req1_b = 8'h30; bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'h22 || bus.rsp_id !== 1'b1 || bus.rsp_exc !== 1'b0 ||
          bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: valid=%b result=%h id=%b exc=%b ready=%b%b required 1 22 1 0 00", i,
                 bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.rsp_exc, bus.req0_ready, bus.req1_ready);
      else passed++;
      @(negedge clk);
    end
    rsp_handshake();
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL bp_release: rsp_valid=%b ready=%b%b required 0 10", bus.rsp_valid, bus.req0_ready, bus.req1_ready);
    else passed++;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    int t; bit ok, seen;
    fu_delay = -1; seen = 0;
    send(0, OP_ADD, 8'h40, 8'h38, t, ok);
    repeat (3) @(negedge clk);
    checks++; if (bus.fu_a !== 8'h40) $display("FAIL rst_pre_fu_a: got %h required 40", bus.fu_a); else passed++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.fu_a !== 8'h00 || bus.exc_a !== 8'h00 || bus.fu_start !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_result !== 8'h00 || bus.rsp_id !== 1'b0)
      $display("FAIL rst_async: fu_a=%h exc_a=%h fu_start=%b rsp_valid=%b rsp_result=%h rsp_id=%b required all 0",
               bus.fu_a, bus.exc_a, bus.fu_start, bus.rsp_valid, bus.rsp_result, bus.rsp_id);
    else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) seen = 1;
      @(negedge clk);
    end
    checks++; if (seen) $display("FAIL rst_no_rsp: rsp_valid seen=1 required 0"); else passed++;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL rst_first_tie: ready=%b%b required 10", bus.req0_ready, bus.req1_ready);
    else passed++;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clean_op();
    test_exception();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed", passed, checks);
    $fatal(1);
  end
endmodule
